gnss_sample_packer: RTL and testbench

GNSS_SAMPLE_PACKER -- requirements
Module: gnss_sample_packer

---
 rtl/gnss_pkg.sv | 17 +
 rtl/gnss_sample_packer_if.sv | 25 ++
 rtl/gnss_word_fifo.sv | 64 ++++++
 rtl/gnss_sample_packer.sv | 160 ++++++++++++++++
 tb/tb_gnss_sample_packer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/gnss_pkg.sv
// Shared types and defaults for the GNSS front-end sample packer.
// Sample code is {sign, mag}, as delivered by the RF front end.
package gnss_pkg;

  localparam int SAMPLES_PER_WORD_DEF = 16;
  localparam int FIFO_DEPTH_DEF       = 4;

  typedef struct packed {
    logic sign;
    logic mag;
  } sample_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gnss_sample_packer_if.sv
// Packed-word output stream: valid/ready handshake toward the correlator.
// Master drives data/valid, slave drives ready.
interface gnss_sample_packer_if
  import gnss_pkg::*;
#(
  parameter int W = 2 * SAMPLES_PER_WORD_DEF
) ();

  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/gnss_word_fifo.sv
// Registered word FIFO with valid/ready on both sides.
// Read data is forced to zero while empty so reset yields a clean bus.
module gnss_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_out_valid = ~o_empty;
  assign w_pop       = o_out_valid & i_out_ready;
  // A pop in the same cycle frees the slot a full push needs
  assign o_in_ready  = ~o_full | w_pop;
  assign w_push      = i_in_valid & o_in_ready;
  assign o_out_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gnss_sample_packer.sv
// Synchronizes 2-bit GNSS front-end samples into sys_clk and packs
// them LSB-first into words buffered by a small FIFO.
module gnss_sample_packer
  import gnss_pkg::*;
#(
  parameter int SAMPLES_PER_WORD = SAMPLES_PER_WORD_DEF,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fe_clk,
  input  logic                  fe_sign,
  input  logic                  fe_mag,
  gnss_sample_packer_if.master  m,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic [15:0]           drop_cnt
);

  localparam int W  = 2 * SAMPLES_PER_WORD;
  localparam int CW = cnt_w(SAMPLES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]    r_fc;
  logic [1:0]    r_fs;
  logic [1:0]    r_fm;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_word;
  logic          r_push;
  logic          r_ovf;
  logic [15:0]   r_drop;

  logic          w_edge;
  logic          w_cap;
  logic          w_last;
  sample_t       w_code;
  logic [W-1:0]  w_word;
  logic          w_in_ready;
  logic          w_out_valid;
  logic [W-1:0]  w_out_data;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;

  assign w_edge = r_fc[1] & ~r_fc[2];
  assign w_code = '{sign: r_fs[1], mag: r_fm[1]};
  assign w_last = (r_cnt == CW'(SAMPLES_PER_WORD - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_fc <= '0;
      r_fs <= '0;
      r_fm <= '0;
    end else begin
      r_fc <= {r_fc[1:0], fe_clk};
      r_fs <= {r_fs[0], fe_sign};
      r_fm <= {r_fm[0], fe_mag};
    end
  end

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next = ALIGN;
      end
      ALIGN: begin
        if (!enable) begin
          w_next = IDLE;
        end else if (w_edge) begin
          w_cap  = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        if (!enable) w_next = IDLE;
        else         w_cap  = w_edge;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_word = r_word;
    w_word[2*int'(r_cnt) +: 2] = w_code;
  end

  // A partial word is abandoned by rewinding the counter on exit
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_push  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_push  <= w_cap & w_last;
      if (w_cap) begin
        r_word <= w_word;
        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end else if (w_next == IDLE) begin
        r_cnt  <= '0;
      end
    end
  end

  gnss_word_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (sys_clk),
    .rst         (rst),
    .i_in_valid  (r_push),
    .o_in_ready  (w_in_ready),
    .i_in_data   (r_word),
    .o_out_valid (w_out_valid),
    .i_out_ready (m.m_ready),
    .o_out_data  (w_out_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign m.m_valid = w_out_valid;
  assign m.m_data  = w_out_data;

  assign w_drop = r_push & ~w_in_ready;

  // A drop in the same cycle as clear_ovf wins
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_drop)         r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign overflow = r_ovf;
  assign drop_cnt = r_drop;

  a_fifo_flags : assert property (
    @(posedge sys_clk) disable iff (rst)
    !(w_full && w_empty) && (w_empty == !w_out_valid)
  );

endmodule

// File: tb/tb_gnss_sample_packer.sv
// Directed bench for gnss_sample_packer: hand-picked words are
// serialized onto fe_sign/fe_mag and checked against a queue.
module tb_gnss_sample_packer;
  import gnss_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fe_clk;
  logic        fe_sign;
  logic        fe_mag;
  logic        clear_ovf;
  logic        overflow;
  logic [15:0] drop_cnt;

  gnss_sample_packer_if #(.W(32)) bus ();

  gnss_sample_packer dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .enable    (enable),
    .fe_clk    (fe_clk),
    .fe_sign   (fe_sign),
    .fe_mag    (fe_mag),
    .m         (bus),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .drop_cnt  (drop_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge sys_clk);
  endtask

  // fe_clk period is 4 sys_clk cycles; the edge is captured 3 later
  task automatic send_word(input logic [31:0] w, input int n,
                           input bit rdy_pulse, input bit clr_pulse);
    logic [1:0] c;
    for (int k = 0; k < n; k++) begin
      c       = w[2*k +: 2];
      fe_clk  = 1'b0;
      fe_sign = c[1];
      fe_mag  = c[0];
      tick();
      tick();
      fe_clk = 1'b1;
      if (k == 15 && (rdy_pulse || clr_pulse)) begin
        tick();
        tick();
        tick();
        if (rdy_pulse) bus.m_ready = 1'b1;
        if (clr_pulse) clear_ovf = 1'b1;
        tick();
        if (rdy_pulse) bus.m_ready = 1'b0;
        clear_ovf = 1'b0;
      end else begin
        tick();
        tick();
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);
  endtask

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (stall_prev && bus.m_valid) check("stable", bus.m_data, stall_data);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
        else check("word", bus.m_data, exp_q.pop_front());
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s2w [6];
    s2w = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98,
            32'h7654_3210, 32'hAAAA_5555, 32'h0F0F_F0F0};

    rst = 1'b1; enable = 1'b0; fe_clk = 1'b0; fe_sign = 1'b0;
    fe_mag = 1'b0; clear_ovf = 1'b0; bus.m_ready = 1'b0;
    repeat (3) tick();
    at_neg();
    check("rst_valid", bus.m_valid, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // Streaming with ready held high
    enable = 1'b1; bus.m_ready = 1'b1;
    repeat (3) tick();
    exp_q.push_back(32'hE4E4_E4E4);
    send_word(32'hE4E4_E4E4, 16, 0, 0);
    exp_q.push_back(32'h1B2D_3C4F);
    send_word(32'h1B2D_3C4F, 16, 0, 0);
    drain();
    at_neg();
    check("s1_ovf", overflow, 0);
    check("s1_drop", drop_cnt, 0);
    tick();

    // Six words into a stalled 4-deep FIFO; clear collides with drop
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(s2w[i]);
    for (int i = 0; i < 6; i++) send_word(s2w[i], 16, 0, i == 5);
    repeat (4) tick();
    at_neg();
    check("s2_ovf", overflow, 1);
    check("s2_drop", drop_cnt, 2);
    check("s2_valid", bus.m_valid, 1);
    check("s2_head", bus.m_data, 32'h0123_4567);
    tick();
    bus.m_ready = 1'b1;
    drain();

    // Clear with no competing drop
    tick();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    at_neg();
    check("s6_ovf", overflow, 0);
    check("s6_drop", drop_cnt, 2);
    tick();

    // Partial word abandoned by enable drop
    send_word(32'hC3C3_C3C3, 10, 0, 0);
    repeat (2) tick();
    enable = 1'b0;
    repeat (4) tick();
    at_neg();
    check("s3_novalid", bus.m_valid, 0);
    tick();
    enable = 1'b1;
    repeat (3) tick();
    exp_q.push_back(32'h5A5A_A5A5);
    send_word(32'h5A5A_A5A5, 16, 0, 0);
    drain();

    // Push into a full FIFO in the same cycle as a pop
    bus.m_ready = 1'b0;
    exp_q.push_back(32'h1111_2222);
    exp_q.push_back(32'h3333_4444);
    exp_q.push_back(32'h5555_6666);
    exp_q.push_back(32'h7777_8888);
    exp_q.push_back(32'h9999_AAAA);
    send_word(32'h1111_2222, 16, 0, 0);
    send_word(32'h3333_4444, 16, 0, 0);
    send_word(32'h5555_6666, 16, 0, 0);
    send_word(32'h7777_8888, 16, 0, 0);
    send_word(32'h9999_AAAA, 16, 1, 0);
    repeat (4) tick();
    at_neg();
    check("s4_drop", drop_cnt, 2);
    check("s4_ovf", overflow, 0);
    check("s4_head", bus.m_data, 32'h3333_4444);
    tick();
    bus.m_ready = 1'b1;
    drain();

    // Reset with two words buffered
    bus.m_ready = 1'b0;
    send_word(32'h2468_ACE0, 16, 0, 0);
    send_word(32'h1357_9BDF, 16, 0, 0);
    fe_clk = 1'b0;
    repeat (4) tick();
    at_neg();
    check("s5_pre_valid", bus.m_valid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg();
    check("s5_valid", bus.m_valid, 0);
    check("s5_data", bus.m_data, 0);
    check("s5_drop", drop_cnt, 0);
    check("s5_ovf", overflow, 0);
    tick();
    bus.m_ready = 1'b1;
    repeat (3) tick();
    exp_q.push_back(32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF, 16, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
